// File: rtl/div_32.sv
// Sequential signed 32/32 divider: non-restoring magnitude division, one quotient
// bit per clock, then a sign-fixup cycle. Quotient on LO, remainder on HI.
module div_32 (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_FIXUP  = 2'd2;

  // 33-bit magnitude so that -2^31 is representable
  function automatic logic [32:0] mag33(input logic [31:0] v);
    logic [32:0] ext;
    ext = {v[31], v};
    if (v[31]) begin
      mag33 = 33'd0 - ext;
    end else begin
      mag33 = ext;
    end
  endfunction

  logic [1:0]  state_r;
  logic [4:0]  count_r;
  logic [32:0] rem_r;
  logic [31:0] quot_r;
  logic [32:0] divisor_r;
  logic        sign_q_r;
  logic        sign_rem_r;

  logic [32:0] b_mag_s;
  logic [31:0] a_mag_s;
  logic [32:0] shifted_s;
  logic [32:0] rem_step_s;
  logic [31:0] quot_step_s;
  logic [31:0] rem_fix_s;
  logic [31:0] lo_fix_s;
  logic [31:0] hi_fix_s;

  // Operand magnitudes, one non-restoring step, and the final sign correction
  always_comb begin
    b_mag_s     = mag33(B);
    a_mag_s     = A[31] ? (32'd0 - A) : A;
    shifted_s   = {rem_r[31:0], quot_r[31]};
    rem_step_s  = 33'd0;
    rem_fix_s   = 32'd0;
    lo_fix_s    = 32'd0;
    hi_fix_s    = 32'd0;
    if (!rem_r[32]) begin
      rem_step_s = shifted_s - divisor_r;
    end else begin
      rem_step_s = shifted_s + divisor_r;
    end
    quot_step_s = {quot_r[30:0], ~rem_step_s[32]};
    // Final remainder lies in [0, |B|) so 32 bits suffice after correction
    if (rem_r[32]) begin
      rem_fix_s = rem_r[31:0] + divisor_r[31:0];
    end else begin
      rem_fix_s = rem_r[31:0];
    end
    if (div_by_zero) begin
      // No iterations ran: quot_r still holds |A|, so HI restores the dividend
      lo_fix_s = 32'hFFFF_FFFF;
      hi_fix_s = sign_rem_r ? (32'd0 - quot_r) : quot_r;
    end else begin
      lo_fix_s = sign_q_r   ? (32'd0 - quot_r)    : quot_r;
      hi_fix_s = sign_rem_r ? (32'd0 - rem_fix_s) : rem_fix_s;
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r     <= ST_IDLE;
      count_r     <= 5'd0;
      rem_r       <= 33'd0;
      quot_r      <= 32'd0;
      divisor_r   <= 33'd0;
      sign_q_r    <= 1'b0;
      sign_rem_r  <= 1'b0;
      HI          <= 32'd0;
      LO          <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            divisor_r   <= b_mag_s;
            quot_r      <= a_mag_s;
            rem_r       <= 33'd0;
            count_r     <= 5'd0;
            sign_q_r    <= A[31] ^ B[31];
            sign_rem_r  <= A[31];
            div_by_zero <= (B == 32'd0);
            busy        <= 1'b1;
            state_r     <= (B == 32'd0) ? ST_FIXUP : ST_DIVIDE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DIVIDE: begin
          rem_r   <= rem_step_s;
          quot_r  <= quot_step_s;
          count_r <= count_r + 5'd1;
          if (count_r == 5'd31) begin
            state_r <= ST_FIXUP;
          end else begin
            state_r <= ST_DIVIDE;
          end
        end
        ST_FIXUP: begin
          LO      <= lo_fix_s;
          HI      <= hi_fix_s;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_32.sv
// Directed self-checking bench for div_32 with hand-computed quotients/remainders.
module tb_div_32;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int vectors;
  int miscompares;
  int cyc;

  div_32 dut (
    .clk(clk), .clr(clr), .start(start), .A(A), .B(B),
    .HI(HI), .LO(LO), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done, sampling #1 after each rising edge
  task automatic wait_done(input int t0, output int lat, output int bc);
    bc = 0;
    while (done !== 1'b1 && (cyc - t0) < 80) begin
      if (busy === 1'b1) bc++;
      @(posedge clk);
      #1;
    end
    lat = cyc - t0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] elo, input logic [31:0] ehi,
                       input logic edbz, input int elat);
    int t0;
    int lat;
    int bc;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    A = $urandom; B = $urandom;
    wait_done(t0, lat, bc);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_busycyc"}, bc, elat);
    chk({tag, "_lo"}, LO, elo);
    chk({tag, "_hi"}, HI, ehi);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
  endtask

  initial begin
    int t0;
    int lat;
    int bc;
    logic seen;
    vectors = 0; miscompares = 0; cyc = 0;
    clr = 1'b0; start = 1'b0; A = 32'd0; B = 32'd0;
    #12;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    do_op("p100_7",   32'd100,          32'd7,          32'd14,         32'd2,          1'b0, 33);
    do_op("n100_7",   32'hFFFF_FF9C,    32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 33);
    do_op("p100_n7",  32'd100,          32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 33);
    do_op("n100_n7",  32'hFFFF_FF9C,    32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 33);
    do_op("min_n1",   32'h8000_0000,    32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33);
    do_op("max_1",    32'h7FFF_FFFF,    32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0, 33);
    do_op("min_7",    32'h8000_0000,    32'd7,          32'hEDB6_DB6E,  32'hFFFF_FFFE,  1'b0, 33);
    do_op("p3_5",     32'd3,            32'd5,          32'd0,          32'd3,          1'b0, 33);
    do_op("zero_5",   32'd0,            32'd5,          32'd0,          32'd0,          1'b0, 33);
    do_op("p5_0",     32'd5,            32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1);
    do_op("n8_0",     32'hFFFF_FFF8,    32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF8,  1'b1, 1);
    do_op("p9_3",     32'd9,            32'd3,          32'd3,          32'd0,          1'b0, 33);

    // Results hold while idle
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("hold_lo", LO, 32'd3);
    chk("hold_done", {31'd0, done}, 32'd0);

    // A start pulse mid-operation is ignored
    @(negedge clk);
    A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    A = 32'd1; B = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    wait_done(t0, lat, bc);
    chk("ign_lat", lat, 33);
    chk("ign_lo", LO, 32'd14);
    chk("ign_hi", HI, 32'd2);

    // start held through done: second op accepted in the done cycle; A/B change mid-op
    @(negedge clk);
    A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    repeat (5) @(posedge clk);
    @(negedge clk);
    A = 32'd20; B = 32'd6;
    #1;
    wait_done(t0, lat, bc);
    chk("b2b_lat1", lat, 33);
    chk("b2b_lo1", LO, 32'd14);
    chk("b2b_hi1", HI, 32'd2);
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_ndone", {31'd0, done}, 32'd0);
    wait_done(t0, lat, bc);
    chk("b2b_lat2", lat, 33);
    chk("b2b_lo2", LO, 32'd3);
    chk("b2b_hi2", HI, 32'd2);

    // Asynchronous reset mid-operation
    @(negedge clk);
    A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    clr = 1'b0;
    #1;
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk("arst_idle", {31'd0, seen}, 32'd0);
    do_op("post_rst", 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
